// File: rtl/hack_cpu_ctrl_if.sv
// Hack CPU control bus: instruction fetch, data memory and ALU links.
// master = controller side, slave = memory/ALU environment side.
interface hack_cpu_ctrl_if #(
  parameter int PC_W = 15
);
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [15:0]     inM;
  logic            mem_ready;
  logic            readM;
  logic            writeM;
  logic [PC_W-1:0] addressM;
  logic [15:0]     outM;
  logic [15:0]     alu_x;
  logic [15:0]     alu_y;
  logic [5:0]      alu_ctl;
  logic [15:0]     alu_out;
  logic            alu_zr;
  logic            alu_ng;

  modport master (
    input  instr, instr_valid, inM, mem_ready,
    input  alu_out, alu_zr, alu_ng,
    output instr_ready, pc, readM, writeM,
    output addressM, outM, alu_x, alu_y, alu_ctl
  );

  modport slave (
    output instr, instr_valid, inM, mem_ready,
    output alu_out, alu_zr, alu_ng,
    input  instr_ready, pc, readM, writeM,
    input  addressM, outM, alu_x, alu_y, alu_ctl
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU multi-cycle control/register stage (A, D, PC, IR, MDR).
// Optional HACK_CTRL_HALT_DETECT_EN: jump-to-self parks in HALT.
module hack_cpu_ctrl #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  hack_cpu_ctrl_if.master bus
`ifdef HACK_CTRL_HALT_DETECT_EN
  ,
  output logic halted
`endif
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT
  } state_t;

  state_t state_q, state_n;

  logic [15:0]     a_q, d_q, ir_q, mdr_q;
  logic [15:0]     out_q;
  logic [PC_W-1:0] pc_q, adr_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] a_adr;

  logic pos, jump, halt_hit;
  logic ld_ir, ld_a_imm, ld_adr_a, ld_mdr;
  logic ld_exec, ld_wr, pc_inc_en, pc_jmp;

  assign pc_inc = pc_q + PC_W'(1);
  assign a_adr  = a_q[PC_W-1:0];

  assign pos  = !bus.alu_ng && !bus.alu_zr;
  assign jump = (ir_q[2] && bus.alu_ng)
             || (ir_q[1] && bus.alu_zr)
             || (ir_q[0] && pos);

`ifdef HACK_CTRL_HALT_DETECT_EN
  // pc still holds the current instruction's address in EXEC
  assign halt_hit = jump && (a_adr == pc_q);
  assign halted   = (state_q == HALT);
`else
  assign halt_hit = 1'b0;
`endif

  assign bus.instr_ready = (state_q == FETCH);
  assign bus.readM       = (state_q == MEM_RD);
  assign bus.writeM      = (state_q == MEM_WR);
  assign bus.pc          = pc_q;
  assign bus.addressM    = adr_q;
  assign bus.outM        = out_q;
  assign bus.alu_x       = d_q;
  assign bus.alu_y       = ir_q[12] ? mdr_q : a_q;
  assign bus.alu_ctl     = ir_q[11:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    ld_ir     = 1'b0;
    ld_a_imm  = 1'b0;
    ld_adr_a  = 1'b0;
    ld_mdr    = 1'b0;
    ld_exec   = 1'b0;
    ld_wr     = 1'b0;
    pc_inc_en = 1'b0;
    pc_jmp    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ld_ir   = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          !ir_q[15]: begin
            ld_a_imm  = 1'b1;
            pc_inc_en = 1'b1;
            state_n   = FETCH;
          end
          ir_q[15] && ir_q[12]: begin
            ld_adr_a = 1'b1;
            state_n  = MEM_RD;
          end
          ir_q[15] && !ir_q[12]: begin
            state_n = EXEC;
          end
          default: state_n = FETCH;
        endcase
      end
      MEM_RD: begin
        if (bus.mem_ready) begin
          ld_mdr  = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        ld_exec   = 1'b1;
        pc_jmp    = jump;
        pc_inc_en = !jump;
        if (halt_hit) begin
          state_n = HALT;
        end else if (ir_q[3]) begin
          ld_wr   = 1'b1;
          state_n = MEM_WR;
        end else begin
          state_n = FETCH;
        end
      end
      MEM_WR: begin
        if (bus.mem_ready) state_n = FETCH;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // jump target and write address use A before any EXEC write to A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
      out_q <= '0;
      adr_q <= '0;
      pc_q  <= RESET_PC;
    end else begin
      if (ld_ir)    ir_q  <= bus.instr;
      if (ld_a_imm) a_q   <= ir_q;
      if (ld_adr_a) adr_q <= a_adr;
      if (ld_mdr)   mdr_q <= bus.inM;
      if (ld_exec && ir_q[5]) a_q <= bus.alu_out;
      if (ld_exec && ir_q[4]) d_q <= bus.alu_out;
      if (ld_wr) begin
        out_q <= bus.alu_out;
        adr_q <= a_adr;
      end
      if (pc_jmp)         pc_q <= a_adr;
      else if (pc_inc_en) pc_q <= pc_inc;
    end
  end

endmodule
